// File: rtl/turnstile_credit_ctrl.sv
// Credit-pool turnstile controller: multi-value coins, fare deduction, saturating credit, pass counter, forced-push alarm.
// Optional refund port pair is enabled by defining TURNSTILE_REFUND_EN.
module turnstile_credit_ctrl #(
   parameter int unsigned CREDIT_W     = 8,
   parameter int unsigned COIN_W       = 4,
   parameter int unsigned FARE         = 1,
   parameter int unsigned PASS_W       = 16,
   parameter int unsigned ALARM_CYCLES = 4
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                coin_i,
   input  logic [COIN_W-1:0]   coin_value_i,
   input  logic                push_i,
`ifdef TURNSTILE_REFUND_EN
   input  logic                refund_i,
   output logic [CREDIT_W-1:0] refund_value_o,
`endif
   output logic                locked_o,
   output logic                unlocked_o,
   output logic                alarm_o,
   output logic [CREDIT_W-1:0] credit_o,
   output logic                pass_o,
   output logic [PASS_W-1:0]   pass_count_o,
   output logic                overflow_o
);

   localparam int unsigned SUM_W  = ((COIN_W > CREDIT_W) ? COIN_W : CREDIT_W) + 1;
   localparam int unsigned ACNT_W = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
   localparam logic [CREDIT_W-1:0] CREDIT_MAX = '1;
   localparam logic [CREDIT_W-1:0] FARE_V     = CREDIT_W'(FARE);
   localparam logic [ACNT_W-1:0]   ALARM_LOAD = ACNT_W'(ALARM_CYCLES - 1);

   if (FARE < 1 || 64'(FARE) > ((64'd1 << CREDIT_W) - 64'd1)) begin : g_bad_fare
      $error("turnstile_credit_ctrl: FARE out of range 1..2^CREDIT_W-1");
   end
   if (ALARM_CYCLES < 1) begin : g_bad_alarm
      $error("turnstile_credit_ctrl: ALARM_CYCLES must be >= 1");
   end

   typedef enum logic [2:0] {
      ST_LOCKED   = 3'b001,
      ST_UNLOCKED = 3'b010,
      ST_ALARM    = 3'b100
   } state_t;

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic                pass_q, pass_d;
   logic [PASS_W-1:0]   count_q, count_d;
   logic                overflow_q, overflow_d;
   logic [ACNT_W-1:0]   acnt_q, acnt_d;
   logic [COIN_W-1:0]   coin_add;
   logic                pass_acc;
   logic [SUM_W-1:0]    sum;
`ifdef TURNSTILE_REFUND_EN
   logic [CREDIT_W-1:0] refund_q, refund_d;
`endif

   // State and datapath registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_LOCKED;
         credit_q   <= '0;
         pass_q     <= 1'b0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         acnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         credit_q   <= credit_d;
         pass_q     <= pass_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         acnt_q     <= acnt_d;
      end
   end

`ifdef TURNSTILE_REFUND_EN
   always_ff @(posedge clk_i) begin
      if (rst_i) refund_q <= '0;
      else       refund_q <= refund_d;
   end
   assign refund_value_o = refund_q;
`endif

   // Credit arithmetic, pass accounting and next-state selection
   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      pass_d     = 1'b0;
      count_d    = count_q;
      overflow_d = overflow_q;
      acnt_d     = acnt_q;
`ifdef TURNSTILE_REFUND_EN
      refund_d   = '0;
`endif

      coin_add = coin_i ? coin_value_i : '0;
      pass_acc = push_i && (state_q == ST_UNLOCKED) && (credit_q >= FARE_V);
      sum      = SUM_W'(credit_q) + SUM_W'(coin_add) - (pass_acc ? SUM_W'(FARE_V) : SUM_W'(0));

      if (sum > SUM_W'(CREDIT_MAX)) begin
         credit_d   = CREDIT_MAX;
         overflow_d = 1'b1;
      end else begin
         credit_d = sum[CREDIT_W-1:0];
      end

      if (pass_acc) begin
         pass_d  = 1'b1;
         count_d = count_q + PASS_W'(1);
      end

      case (state_q)
         ST_LOCKED: begin
            if (push_i && (credit_d < FARE_V)) begin
               state_d = ST_ALARM;
               acnt_d  = ALARM_LOAD;
            end else if (credit_d >= FARE_V) begin
               state_d = ST_UNLOCKED;
            end
         end
         ST_UNLOCKED: state_d = (credit_d >= FARE_V) ? ST_UNLOCKED : ST_LOCKED;
         ST_ALARM: begin
            if (credit_d >= FARE_V)         state_d = ST_UNLOCKED;
            else if (acnt_q == '0)          state_d = ST_LOCKED;
            else                            acnt_d  = acnt_q - ACNT_W'(1);
         end
         default: state_d = ST_LOCKED;
      endcase

`ifdef TURNSTILE_REFUND_EN
      // Refund overrides coin and push: coin lost, no pass, overflow untouched
      if (refund_i) begin
         refund_d   = credit_q;
         credit_d   = '0;
         state_d    = ST_LOCKED;
         pass_d     = 1'b0;
         count_d    = count_q;
         overflow_d = overflow_q;
         acnt_d     = '0;
      end
`endif
   end

   assign locked_o     = state_q[0];
   assign unlocked_o   = state_q[1];
   assign alarm_o      = state_q[2];
   assign credit_o     = credit_q;
   assign pass_o       = pass_q;
   assign pass_count_o = count_q;
   assign overflow_o   = overflow_q;

endmodule
